// File: rtl/fsm_pkg.sv
// Shared types and constants for the fsmifc frame decoder.
// Optional feature macro: FSM_ERR_CNT_EN (adds a saturating error counter).
package fsm_pkg;

  typedef enum logic [1:0] {
    INIT   = 2'd0,
    DECODE = 2'd1,
    IDLE   = 2'd2
  } fsmstate_e;

  localparam int DATA_W_DEF      = 8;
  localparam int INIT_CYCLES_DEF = 4;
  localparam int ERR_CNT_W       = 8;

endpackage

// File: rtl/fsm_frame_decoder_if.sv
// Bundle of the fsmifc serial input and decoder status outputs.
// Optional feature macro: FSM_ERR_CNT_EN (adds err_cnt to the bundle).
interface fsm_frame_decoder_if #(
  parameter int DATA_W = fsm_pkg::DATA_W_DEF
) ();
  import fsm_pkg::*;

  logic              pi;
  logic              po;
  logic              err;
  fsmstate_e         state;
  logic [DATA_W-1:0] data_o;
`ifdef FSM_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt;

  modport master (output pi, input po, input err, input state, input data_o, input err_cnt);
  modport slave  (input pi, output po, output err, output state, output data_o, output err_cnt);
`else
  modport master (output pi, input po, input err, input state, input data_o);
  modport slave  (input pi, output po, output err, output state, output data_o);
`endif

endinterface

// File: rtl/fsm_deser.sv
// Frame deserializer: LSB-first shift register, data-bit counter and running
// parity. parity_ok is evaluated against the bit currently on pi, so it is
// meaningful on the parity edge (last_bit high).
module fsm_deser #(
  parameter int DATA_W     = fsm_pkg::DATA_W_DEF,
  parameter int PARITY_ODD = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              shift_en,
  input  logic              clr,
  input  logic              pi,
  output logic [DATA_W-1:0] payload,
  output logic              last_bit,
  output logic              parity_ok
);

  localparam int  CW  = $clog2(DATA_W + 1);
  localparam logic PAR = (PARITY_ODD != 0);

  logic [CW-1:0]     cnt_p0;
  logic [DATA_W-1:0] sreg_p0;
  logic              acc_p0;
  logic [DATA_W:0]   shifted;

  // New bit enters at the MSB so the first bit received ends up at bit 0.
  always_comb begin
    shifted = {pi, sreg_p0};
  end

  // Shift register, bit counter and parity accumulator.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_p0  <= '0;
      sreg_p0 <= '0;
      acc_p0  <= 1'b0;
    end else if (clr) begin
      cnt_p0  <= '0;
      sreg_p0 <= '0;
      acc_p0  <= 1'b0;
    end else if (shift_en) begin
      cnt_p0  <= cnt_p0 + CW'(1);
      sreg_p0 <= shifted[DATA_W:1];
      acc_p0  <= acc_p0 ^ pi;
    end
  end

  assign payload   = sreg_p0;
  assign last_bit  = (cnt_p0 == CW'(DATA_W));
  assign parity_ok = ((acc_p0 ^ pi) == PAR);

endmodule

// File: rtl/fsm_frame_decoder.sv
// fsmifc frame decoder: INIT hold-off, then start/data/parity frames on pi.
// Good-parity frames pulse po and update data_o; bad-parity frames pulse err.
// Optional feature macro: FSM_ERR_CNT_EN (saturating 8-bit count of err pulses).
module fsm_frame_decoder
  import fsm_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int INIT_CYCLES = INIT_CYCLES_DEF,
  parameter int PARITY_ODD  = 0
) (
  input  logic             clk,
  input  logic             reset,
  fsm_frame_decoder_if.slave bus
);

  localparam int ICW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam logic [ICW-1:0] INIT_LAST = ICW'(INIT_CYCLES - 1);

  fsmstate_e         state_q, state_d;
  logic [ICW-1:0]    init_cnt_q;
  logic              shift_en, clr, frame_done;
  logic [DATA_W-1:0] payload;
  logic              last_bit, parity_ok;
  logic              po_q, err_q;
  logic [DATA_W-1:0] data_q;

  fsm_deser #(
    .DATA_W     (DATA_W),
    .PARITY_ODD (PARITY_ODD)
  ) u_deser (
    .clk       (clk),
    .reset     (reset),
    .shift_en  (shift_en),
    .clr       (clr),
    .pi        (bus.pi),
    .payload   (payload),
    .last_bit  (last_bit),
    .parity_ok (parity_ok)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= INIT;
    else       state_q <= state_d;
  end

  // INIT hold-off counter; only advances while in INIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                init_cnt_q <= '0;
    else if (state_q == INIT) init_cnt_q <= init_cnt_q + ICW'(1);
  end

  // Next-state and deserializer control.
  always_comb begin
    state_d    = state_q;
    shift_en   = 1'b0;
    clr        = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      INIT: begin
        if (init_cnt_q == INIT_LAST) state_d = IDLE;
      end
      IDLE: begin
        if (bus.pi) begin
          state_d = DECODE;
          clr     = 1'b1;
        end
      end
      DECODE: begin
        if (last_bit) begin
          state_d    = IDLE;
          frame_done = 1'b1;
        end else begin
          shift_en = 1'b1;
        end
      end
      default: state_d = INIT;
    endcase
  end

  // Frame result registers: one-cycle po/err, data_o holds the last good payload.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      po_q   <= 1'b0;
      err_q  <= 1'b0;
      data_q <= '0;
    end else begin
      po_q  <= frame_done & parity_ok;
      err_q <= frame_done & ~parity_ok;
      if (frame_done && parity_ok) data_q <= payload;
    end
  end

`ifdef FSM_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q;

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : v + ERR_CNT_W'(1);
  endfunction

  // Error counter advances together with each err pulse and sticks at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                           err_cnt_q <= '0;
    else if (frame_done && !parity_ok)   err_cnt_q <= sat_inc(err_cnt_q);
  end

  assign bus.err_cnt = err_cnt_q;
`endif

  assign bus.state  = state_q;
  assign bus.po     = po_q;
  assign bus.err    = err_q;
  assign bus.data_o = data_q;

endmodule

// File: tb/tb_fsm_frame_decoder.sv
// Directed bench for fsm_frame_decoder (DATA_W=8, INIT_CYCLES=4, even parity).
// Optional feature macro: FSM_ERR_CNT_EN (enables the err_cnt scenario).
module tb_fsm_frame_decoder;
  import fsm_pkg::*;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;
  int   cyc;

  fsm_frame_decoder_if #(.DATA_W(8)) bus ();

  fsm_frame_decoder #(
    .DATA_W      (8),
    .INIT_CYCLES (4),
    .PARITY_ODD  (0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start bit, 8 data bits LSB first, parity bit; returns just after the parity edge.
  task automatic send_frame(input logic [7:0] d, input logic p);
    bus.pi = 1'b1;
    tick();
    n_cmp++;
    if (bus.state !== DECODE) begin
      n_bad++;
      $display("FAIL start_state: got %0d want %0d", bus.state, DECODE);
    end
    for (int i = 0; i < 8; i++) begin
      bus.pi = d[i];
      tick();
      n_cmp++;
      if (bus.state !== DECODE || bus.po !== 1'b0 || bus.err !== 1'b0) begin
        n_bad++;
        $display("FAIL decode_bit%0d: state=%0d po=%b err=%b want state=%0d po=0 err=0",
                 i, bus.state, bus.po, bus.err, DECODE);
      end
    end
    bus.pi = p;
    tick();
    bus.pi = 1'b0;
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    bus.pi = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if (bus.state !== INIT || bus.po !== 1'b0 || bus.err !== 1'b0 || bus.data_o !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_values: state=%0d po=%b err=%b data=%h want 0/0/0/00",
               bus.state, bus.po, bus.err, bus.data_o);
    end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (bus.state !== INIT || bus.po !== 1'b0 || bus.err !== 1'b0 || bus.data_o !== 8'h00) begin
        n_bad++;
        $display("FAIL init_hold%0d: state=%0d po=%b err=%b data=%h want INIT/0/0/00",
                 i, bus.state, bus.po, bus.err, bus.data_o);
      end
      tick();
    end
    n_cmp++;
    if (bus.state !== IDLE) begin
      n_bad++;
      $display("FAIL init_exit: state=%0d want %0d", bus.state, IDLE);
    end
  endtask

  task automatic test_good_frame();
    send_frame(8'hA5, 1'b0);
    n_cmp++;
    if (bus.state !== IDLE || bus.po !== 1'b1 || bus.err !== 1'b0 || bus.data_o !== 8'hA5) begin
      n_bad++;
      $display("FAIL good_frame: state=%0d po=%b err=%b data=%h want IDLE/1/0/a5",
               bus.state, bus.po, bus.err, bus.data_o);
    end
    tick();
    n_cmp++;
    if (bus.po !== 1'b0 || bus.err !== 1'b0 || bus.data_o !== 8'hA5) begin
      n_bad++;
      $display("FAIL good_pulse_len: po=%b err=%b data=%h want 0/0/a5", bus.po, bus.err, bus.data_o);
    end
  endtask

  task automatic test_bad_parity();
    send_frame(8'h5A, 1'b1);
    n_cmp++;
    if (bus.state !== IDLE || bus.po !== 1'b0 || bus.err !== 1'b1 || bus.data_o !== 8'hA5) begin
      n_bad++;
      $display("FAIL bad_parity: state=%0d po=%b err=%b data=%h want IDLE/0/1/a5",
               bus.state, bus.po, bus.err, bus.data_o);
    end
    tick();
    n_cmp++;
    if (bus.po !== 1'b0 || bus.err !== 1'b0 || bus.data_o !== 8'hA5) begin
      n_bad++;
      $display("FAIL bad_pulse_len: po=%b err=%b data=%h want 0/0/a5", bus.po, bus.err, bus.data_o);
    end
  endtask

  task automatic test_back_to_back();
    int t1, t2;
    send_frame(8'h3C, 1'b0);
    t1 = cyc;
    n_cmp++;
    if (bus.state !== IDLE || bus.po !== 1'b1 || bus.data_o !== 8'h3C) begin
      n_bad++;
      $display("FAIL b2b_first: state=%0d po=%b data=%h want IDLE/1/3c", bus.state, bus.po, bus.data_o);
    end
    send_frame(8'hFF, 1'b0);
    t2 = cyc;
    n_cmp++;
    if (bus.state !== IDLE || bus.po !== 1'b1 || bus.err !== 1'b0 || bus.data_o !== 8'hFF) begin
      n_bad++;
      $display("FAIL b2b_second: state=%0d po=%b err=%b data=%h want IDLE/1/0/ff",
               bus.state, bus.po, bus.err, bus.data_o);
    end
    n_cmp++;
    if (t2 - t1 !== 10) begin
      n_bad++;
      $display("FAIL b2b_period: got %0d cycles want 10", t2 - t1);
    end
    tick();
    n_cmp++;
    if (bus.po !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_pulse_len: po=%b want 0", bus.po);
    end
  endtask

  task automatic test_async_reset();
    bus.pi = 1'b1;
    tick();
    bus.pi = 1'b0; tick();
    bus.pi = 1'b1; tick();
    bus.pi = 1'b1; tick();
    #2;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (bus.state !== INIT || bus.po !== 1'b0 || bus.err !== 1'b0 || bus.data_o !== 8'h00) begin
      n_bad++;
      $display("FAIL async_reset: state=%0d po=%b err=%b data=%h want INIT/0/0/00",
               bus.state, bus.po, bus.err, bus.data_o);
    end
    tick();
    reset  = 1'b0;
    bus.pi = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (bus.state !== INIT || bus.po !== 1'b0 || bus.err !== 1'b0 || bus.data_o !== 8'h00) begin
        n_bad++;
        $display("FAIL async_init%0d: state=%0d po=%b err=%b data=%h want INIT/0/0/00",
                 i, bus.state, bus.po, bus.err, bus.data_o);
      end
      tick();
    end
    bus.pi = 1'b0;
    n_cmp++;
    if (bus.state !== IDLE) begin
      n_bad++;
      $display("FAIL async_init_exit: state=%0d want %0d", bus.state, IDLE);
    end
    send_frame(8'hA5, 1'b0);
    n_cmp++;
    if (bus.po !== 1'b1 || bus.err !== 1'b0 || bus.data_o !== 8'hA5) begin
      n_bad++;
      $display("FAIL after_async: po=%b err=%b data=%h want 1/0/a5", bus.po, bus.err, bus.data_o);
    end
    tick();
  endtask

`ifdef FSM_ERR_CNT_EN
  task automatic test_err_cnt();
    n_cmp++;
    if (bus.err_cnt !== 8'd0) begin
      n_bad++;
      $display("FAIL err_cnt_start: got %0d want 0", bus.err_cnt);
    end
    for (int k = 1; k <= 300; k++) begin
      send_frame(8'h5A, 1'b1);
      if (k == 1 || k == 100 || k == 255 || k == 300) begin
        n_cmp++;
        if (bus.err_cnt !== ((k > 255) ? 8'd255 : 8'(k))) begin
          n_bad++;
          $display("FAIL err_cnt_%0d: got %0d want %0d", k, bus.err_cnt, (k > 255) ? 255 : k);
        end
      end
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (bus.err_cnt !== 8'd0) begin
      n_bad++;
      $display("FAIL err_cnt_reset: got %0d want 0", bus.err_cnt);
    end
    tick();
    reset = 1'b0;
    repeat (4) tick();
  endtask
`endif

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    reset  = 1'b1;
    bus.pi = 1'b0;
    test_reset();
    test_good_frame();
    test_bad_parity();
    test_back_to_back();
    test_async_reset();
`ifdef FSM_ERR_CNT_EN
    test_err_cnt();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
